// File: rtl/issue_scoreboard_if.sv
// Decode-to-execute issue bus: decode handshake, writeback and branch
// resolution events, plus scoreboard status returned to the pipeline.
interface issue_scoreboard_if #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STALL_CNT_W     = 16
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                   dec_valid_i;
  logic [4:0]             dec_rs1_addr_i;
  logic [4:0]             dec_rs2_addr_i;
  logic [4:0]             dec_rd_addr_i;
  logic                   dec_uses_rs1_i;
  logic                   dec_uses_rs2_i;
  logic                   dec_reg_write_en_i;
  logic                   dec_branch_i;
  logic                   dec_jump_i;
  logic                   dec_ready_o;
  logic                   issue_fire_o;
  logic                   wb_valid_i;
  logic [4:0]             wb_rd_addr_i;
  logic                   resolve_i;
  logic                   flush_i;
  logic [31:0]            busy_o;
  logic [OUT_W-1:0]       outstanding_o;
  logic                   ctrl_pending_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;
  logic                   wb_err_o;

  // Pipeline side: presents instructions and retirement events.
  modport master (
    output dec_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i,
           dec_uses_rs1_i, dec_uses_rs2_i, dec_reg_write_en_i,
           dec_branch_i, dec_jump_i, wb_valid_i, wb_rd_addr_i,
           resolve_i, flush_i,
    input  dec_ready_o, issue_fire_o, busy_o, outstanding_o,
           ctrl_pending_o, stall_cnt_o, wb_err_o
  );

  // Scoreboard side.
  modport slave (
    input  dec_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i,
           dec_uses_rs1_i, dec_uses_rs2_i, dec_reg_write_en_i,
           dec_branch_i, dec_jump_i, wb_valid_i, wb_rd_addr_i,
           resolve_i, flush_i,
    output dec_ready_o, issue_fire_o, busy_o, outstanding_o,
           ctrl_pending_o, stall_cnt_o, wb_err_o
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue controller: 32-entry busy scoreboard gating decode issue on
// RAW/WAW hazards, the in-flight write limit and unresolved control flow.
module issue_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STALL_CNT_W     = 16
) (
  input logic             clk,
  input logic             rst,
  issue_scoreboard_if.slave bus
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {RUN, CTRL_WAIT} state_t;

  state_t                 state_reg, state_next;
  logic [31:0]            busy_reg, busy_next;
  logic [OUT_W-1:0]       outstanding_reg, outstanding_next, outstanding_eff;
  logic [STALL_CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic                   wb_err_reg, wb_err_next;

  logic [31:0] wb_mask;   // one-hot of a valid writeback target
  logic [31:0] rd_mask;   // one-hot of rd, never bit 0
  logic [31:0] eff_busy;  // busy with same-cycle writeback waived
  logic        wr, wb_hit, ready, fire;
  logic        rs1_haz, rs2_haz, rd_haz, limit_haz;

  // Per-register decode of writeback and destination addresses.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_reg
      assign wb_mask[gi]  = bus.wb_valid_i && (bus.wb_rd_addr_i == 5'(gi));
      assign rd_mask[gi]  = (gi != 0) && (bus.dec_rd_addr_i == 5'(gi));
      assign eff_busy[gi] = busy_reg[gi] & ~wb_mask[gi];
    end
  endgenerate

  assign wr              = bus.dec_reg_write_en_i && (bus.dec_rd_addr_i != 5'd0);
  // Only a writeback that hits a busy entry retires anything.
  assign wb_hit          = |(busy_reg & wb_mask);
  assign outstanding_eff = outstanding_reg - OUT_W'(wb_hit);

  assign rs1_haz   = bus.dec_uses_rs1_i && eff_busy[bus.dec_rs1_addr_i];
  assign rs2_haz   = bus.dec_uses_rs2_i && eff_busy[bus.dec_rs2_addr_i];
  assign rd_haz    = wr && eff_busy[bus.dec_rd_addr_i];
  assign limit_haz = wr && (outstanding_eff == OUT_W'(MAX_OUTSTANDING));

  // Issue gating and next-state for the control-flow FSM.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    case (state_reg)
      RUN: begin
        ready = !(rs1_haz || rs2_haz || rd_haz || limit_haz);
        if (bus.dec_valid_i && ready && (bus.dec_branch_i || bus.dec_jump_i))
          state_next = CTRL_WAIT;
      end
      CTRL_WAIT: begin
        if (bus.resolve_i || bus.flush_i)
          state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign fire = bus.dec_valid_i && ready;

  // Scoreboard, counters and sticky error next-state.
  always_comb begin
    busy_next        = (busy_reg & ~wb_mask) | ((fire && wr) ? rd_mask : 32'd0);
    outstanding_next = outstanding_reg - OUT_W'(wb_hit) + OUT_W'(fire && wr);
    wb_err_next      = wb_err_reg |
                       (bus.wb_valid_i && (bus.wb_rd_addr_i != 5'd0) && !wb_hit);
    stall_cnt_next   = stall_cnt_reg;
    if (bus.dec_valid_i && !ready && (stall_cnt_reg != {STALL_CNT_W{1'b1}}))
      stall_cnt_next = stall_cnt_reg + 1'b1;
  end

  // State registers; reset wins over every same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      busy_reg        <= 32'd0;
      outstanding_reg <= '0;
      stall_cnt_reg   <= '0;
      wb_err_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      busy_reg        <= busy_next;
      outstanding_reg <= outstanding_next;
      stall_cnt_reg   <= stall_cnt_next;
      wb_err_reg      <= wb_err_next;
    end
  end

  assign bus.dec_ready_o    = ready;
  assign bus.issue_fire_o   = fire;
  assign bus.busy_o         = busy_reg;
  assign bus.outstanding_o  = outstanding_reg;
  assign bus.ctrl_pending_o = (state_reg == CTRL_WAIT);
  assign bus.stall_cnt_o    = stall_cnt_reg;
  assign bus.wb_err_o       = wb_err_reg;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Testbench for issue_scoreboard: directed vector table, hand-written
// control-flow/reset sequences, and randomized traffic against a model.
module tb_issue_scoreboard;
  localparam int MAXO = 4;
  localparam int SCW  = 16;
  localparam int SMAX = (1 << SCW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_scoreboard_if #(.MAX_OUTSTANDING(MAXO), .STALL_CNT_W(SCW)) bus ();
  issue_scoreboard #(.MAX_OUTSTANDING(MAXO), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, we, br, jp, wbv;
    logic [4:0] wbrd;
    logic       res, fl, rst;
  } in_t;

  typedef struct {
    in_t         i;
    logic        rdy;
    logic [31:0] busy;
    int          outs;
    logic        pend, err;
    int          stall;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference state: a set of registers awaiting writeback, a pending flag.
  bit mbusy[32];
  bit mpend;
  bit merr;
  int mstall;

  function automatic int mcount();
    int c = 0;
    for (int r = 0; r < 32; r++) if (mbusy[r]) c++;
    return c;
  endfunction

  function automatic logic [31:0] mvec();
    logic [31:0] b = '0;
    for (int r = 0; r < 32; r++) b[r] = mbusy[r];
    return b;
  endfunction

  function automatic bit waits_on(input logic [4:0] r, input in_t t);
    return mbusy[r] && !(t.wbv && t.wbrd == r);
  endfunction

  function automatic bit model_ready(input in_t t);
    bit wr = t.we && (t.rd != 0);
    int inflight = mcount() - ((t.wbv && mbusy[t.wbrd]) ? 1 : 0);
    if (mpend) return 0;
    if (t.u1 && waits_on(t.rs1, t)) return 0;
    if (t.u2 && waits_on(t.rs2, t)) return 0;
    if (wr && waits_on(t.rd, t)) return 0;
    if (wr && inflight == MAXO) return 0;
    return 1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mkin(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic u1, input logic u2,
                               input logic we, input logic br, input logic jp,
                               input logic wbv, input logic [4:0] wbrd);
    in_t t;
    t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.u1 = u1; t.u2 = u2;
    t.we = we; t.br = br; t.jp = jp; t.wbv = wbv; t.wbrd = wbrd;
    t.res = 0; t.fl = 0; t.rst = 0;
    return t;
  endfunction

  // One cycle: drive, check combinational issue, clock, check state.
  task automatic step(input in_t t);
    bit exp_rdy;
    bit wr;
    rst                    = t.rst;
    bus.dec_valid_i        = t.v;
    bus.dec_rs1_addr_i     = t.rs1;
    bus.dec_rs2_addr_i     = t.rs2;
    bus.dec_rd_addr_i      = t.rd;
    bus.dec_uses_rs1_i     = t.u1;
    bus.dec_uses_rs2_i     = t.u2;
    bus.dec_reg_write_en_i = t.we;
    bus.dec_branch_i       = t.br;
    bus.dec_jump_i         = t.jp;
    bus.wb_valid_i         = t.wbv;
    bus.wb_rd_addr_i       = t.wbrd;
    bus.resolve_i          = t.res;
    bus.flush_i            = t.fl;
    #1;
    exp_rdy = model_ready(t);
    chk("dec_ready", bus.dec_ready_o, exp_rdy);
    chk("issue_fire", bus.issue_fire_o, t.v & exp_rdy);
    @(posedge clk);
    if (t.rst) begin
      for (int r = 0; r < 32; r++) mbusy[r] = 0;
      mpend = 0; merr = 0; mstall = 0;
    end else begin
      wr = t.we && (t.rd != 0);
      if (t.wbv) begin
        if (mbusy[t.wbrd]) mbusy[t.wbrd] = 0;
        else if (t.wbrd != 0) merr = 1;
      end
      if (t.v && exp_rdy && wr) mbusy[t.rd] = 1;
      if (t.v && !exp_rdy && mstall < SMAX) mstall++;
      if (!mpend) begin
        if (t.v && exp_rdy && (t.br || t.jp)) mpend = 1;
      end else if (t.res || t.fl) begin
        mpend = 0;
      end
    end
    #1;
    chk("busy", bus.busy_o, mvec());
    chk("outstanding", bus.outstanding_o, mcount());
    chk("ctrl_pending", bus.ctrl_pending_o, mpend);
    chk("stall_cnt", bus.stall_cnt_o, mstall);
    chk("wb_err", bus.wb_err_o, merr);
  endtask

  vec_t vecs[$];
  in_t  t;

  initial begin
    // Directed vectors, expected values derived by hand (MAX_OUTSTANDING=4).
    vecs.push_back('{mkin(1,1,2,5,1,1,1,0,0,0,0), 1, 32'h20, 1, 0, 0, 0}); // ADD x5
    vecs.push_back('{mkin(1,5,0,6,1,0,1,0,0,0,0), 0, 32'h20, 1, 0, 0, 1}); // RAW stall
    vecs.push_back('{mkin(1,5,0,6,1,0,1,0,0,0,0), 0, 32'h20, 1, 0, 0, 2});
    vecs.push_back('{mkin(1,5,0,6,1,0,1,0,0,1,5), 1, 32'h40, 1, 0, 0, 2}); // wb waives
    vecs.push_back('{mkin(0,0,0,0,0,0,0,0,0,1,6), 1, 32'h00, 0, 0, 0, 2});
    vecs.push_back('{mkin(1,0,0,1,0,0,1,0,0,0,0), 1, 32'h02, 1, 0, 0, 2});
    vecs.push_back('{mkin(1,0,0,2,0,0,1,0,0,0,0), 1, 32'h06, 2, 0, 0, 2});
    vecs.push_back('{mkin(1,0,0,3,0,0,1,0,0,0,0), 1, 32'h0E, 3, 0, 0, 2});
    vecs.push_back('{mkin(1,0,0,4,0,0,1,0,0,0,0), 1, 32'h1E, 4, 0, 0, 2});
    vecs.push_back('{mkin(1,0,0,6,0,0,1,0,0,0,0), 0, 32'h1E, 4, 0, 0, 3}); // limit
    vecs.push_back('{mkin(1,0,0,0,0,0,0,0,0,0,0), 1, 32'h1E, 4, 0, 0, 3}); // store
    vecs.push_back('{mkin(1,0,0,6,0,0,1,0,0,1,2), 1, 32'h5A, 4, 0, 0, 3}); // wb frees slot
    vecs.push_back('{mkin(0,0,0,0,0,0,0,0,0,1,1), 1, 32'h58, 3, 0, 0, 3});
    vecs.push_back('{mkin(0,0,0,0,0,0,0,0,0,1,3), 1, 32'h50, 2, 0, 0, 3});
    vecs.push_back('{mkin(0,0,0,0,0,0,0,0,0,1,4), 1, 32'h40, 1, 0, 0, 3});
    vecs.push_back('{mkin(0,0,0,0,0,0,0,0,0,1,6), 1, 32'h00, 0, 0, 0, 3});
    vecs.push_back('{mkin(1,0,0,7,0,0,1,0,0,0,0), 1, 32'h80, 1, 0, 0, 3});
    vecs.push_back('{mkin(1,0,0,7,0,0,1,0,0,1,7), 1, 32'h80, 1, 0, 0, 3}); // same-reg
    vecs.push_back('{mkin(0,0,0,0,0,0,0,0,0,1,9), 1, 32'h80, 1, 0, 1, 3}); // idle wb
    vecs.push_back('{mkin(0,0,0,0,0,0,0,0,0,1,0), 1, 32'h80, 1, 0, 1, 3}); // wb x0
    vecs.push_back('{mkin(1,0,0,0,0,0,1,0,0,0,0), 1, 32'h80, 1, 0, 1, 3}); // rd=0 write
    vecs.push_back('{mkin(0,0,0,0,0,0,0,0,0,1,7), 1, 32'h00, 0, 0, 1, 3});
    vecs.push_back('{mkin(0,0,0,0,0,0,0,0,0,0,0), 1, 32'h00, 0, 0, 1, 3}); // resolve in RUN
    vecs[vecs.size()-1].i.res = 1;

    for (int r = 0; r < 32; r++) mbusy[r] = 0;
    mpend = 0; merr = 0; mstall = 0;
    t = mkin(0,0,0,0,0,0,0,0,0,0,0);
    bus.dec_valid_i = 0; bus.dec_rs1_addr_i = 0; bus.dec_rs2_addr_i = 0;
    bus.dec_rd_addr_i = 0; bus.dec_uses_rs1_i = 0; bus.dec_uses_rs2_i = 0;
    bus.dec_reg_write_en_i = 0; bus.dec_branch_i = 0; bus.dec_jump_i = 0;
    bus.wb_valid_i = 0; bus.wb_rd_addr_i = 0; bus.resolve_i = 0; bus.flush_i = 0;

    // Reset state.
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    #1;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_outstanding", bus.outstanding_o, 0);
    chk("rst_pending", bus.ctrl_pending_o, 0);
    chk("rst_stall", bus.stall_cnt_o, 0);
    chk("rst_wb_err", bus.wb_err_o, 0);
    chk("rst_ready", bus.dec_ready_o, 1);
    @(negedge clk);
    @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      step(vecs[k].i);
      chk($sformatf("vec%0d_busy", k), bus.busy_o, vecs[k].busy);
      chk($sformatf("vec%0d_out", k), bus.outstanding_o, vecs[k].outs);
      chk($sformatf("vec%0d_pend", k), bus.ctrl_pending_o, vecs[k].pend);
      chk($sformatf("vec%0d_err", k), bus.wb_err_o, vecs[k].err);
      chk($sformatf("vec%0d_stall", k), bus.stall_cnt_o, vecs[k].stall);
      $display("vec %0d ready_exp=%0b busy=%08h out=%0d stall=%0d",
               k, vecs[k].rdy, bus.busy_o, bus.outstanding_o, bus.stall_cnt_o);
    end

    // Branch: three stalled cycles, then flush returns to RUN.
    step(mkin(1,0,0,0,0,0,0,1,0,0,0));
    chk("br_pending", bus.ctrl_pending_o, 1);
    repeat (3) step(mkin(1,0,0,0,0,0,0,0,0,0,0));
    chk("br_stall_plus3", bus.stall_cnt_o, 6);
    t = mkin(0,0,0,0,0,0,0,0,0,0,0); t.fl = 1;
    step(t);
    chk("flush_pending", bus.ctrl_pending_o, 0);
    step(mkin(1,0,0,0,0,0,0,0,0,0,0));
    chk("post_flush_stall", bus.stall_cnt_o, 6);
    $display("branch/flush sequence stall=%0d", bus.stall_cnt_o);

    // Reset in CTRL_WAIT with x4..x7 in flight.
    for (int r = 4; r < 8; r++) step(mkin(1,0,0,5'(r),0,0,1,0,0,0,0));
    step(mkin(1,0,0,0,0,0,0,0,1,0,0));
    chk("pre_rst_busy", bus.busy_o, 32'hF0);
    chk("pre_rst_pending", bus.ctrl_pending_o, 1);
    t = mkin(1,0,0,8,0,0,1,0,0,1,5); t.rst = 1;
    step(t);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_out", bus.outstanding_o, 0);
    chk("mid_rst_pending", bus.ctrl_pending_o, 0);
    chk("mid_rst_stall", bus.stall_cnt_o, 0);
    chk("mid_rst_err", bus.wb_err_o, 0);
    $display("reset mid-CTRL_WAIT busy=%08h", bus.busy_o);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      t.v    = ($urandom_range(0, 3) != 0);
      t.rs1  = 5'($urandom_range(0, 7));
      t.rs2  = 5'($urandom_range(0, 7));
      t.rd   = 5'($urandom_range(0, 7));
      t.u1   = 1'($urandom_range(0, 1));
      t.u2   = 1'($urandom_range(0, 1));
      t.we   = ($urandom_range(0, 3) != 0);
      t.br   = ($urandom_range(0, 9) == 0);
      t.jp   = ($urandom_range(0, 14) == 0);
      t.wbv  = 1'($urandom_range(0, 1));
      t.wbrd = 5'($urandom_range(0, 15));
      if (t.wbv && mcount() > 0 && $urandom_range(0, 7) != 0) begin
        int pick = $urandom_range(0, mcount() - 1);
        for (int r = 1; r < 32; r++) begin
          if (mbusy[r]) begin
            if (pick == 0) t.wbrd = 5'(r);
            pick--;
          end
        end
      end
      t.res  = ($urandom_range(0, 3) == 0);
      t.fl   = ($urandom_range(0, 7) == 0);
      t.rst  = ($urandom_range(0, 299) == 0);
      step(t);
    end
    $display("random phase done busy=%08h stall=%0d", bus.busy_o, bus.stall_cnt_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
